// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-lane arbiter for the shared data_memory port
// Lane 0 wins ties; read lane ids ride a tag pipeline back to the issuing lane.
module dmem_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int ReadLatency = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0][XLEN-1:0] req_addr_i,
  input  logic [1:0][XLEN-1:0] req_wdata_i,
  input  logic [1:0][3:0]      req_we_i,
  input  logic [1:0]           req_re_i,
  output logic [1:0]           resp_valid_o,
  output logic [1:0][XLEN-1:0] resp_rdata_o,
  input  logic                 flush_i,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  output logic [3:0]           dmem_we_o,
  output logic                 dmem_re_o,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  output logic                 busy_o
);

  logic                   accept0;
  logic                   accept1;
  logic                   accept;
  logic                   sel_lane;
  logic                   issue_lane;
  logic [ReadLatency-1:0] tag_v;
  logic [ReadLatency-1:0] tag_lane;

  // Lane 1 yields whenever lane 0 is valid, which keeps program order.
  always_comb begin
    req_ready_o[0] = !reset && !flush_i;
    req_ready_o[1] = !reset && !flush_i && !req_valid_i[0];
    accept0        = req_valid_i[0] && req_ready_o[0];
    accept1        = req_valid_i[1] && req_ready_o[1];
    accept         = accept0 || accept1;
    sel_lane       = !accept0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_we_o    <= '0;
      dmem_re_o    <= 1'b0;
      issue_lane   <= 1'b0;
    end else begin
      dmem_we_o <= '0;
      dmem_re_o <= 1'b0;
      if (accept) begin
        dmem_addr_o  <= req_addr_i[sel_lane];
        dmem_wdata_o <= req_wdata_i[sel_lane];
        dmem_we_o    <= req_we_i[sel_lane];
        dmem_re_o    <= (req_we_i[sel_lane] == 4'h0) && req_re_i[sel_lane];
        issue_lane   <= sel_lane;
      end
    end
  end

  // A flush also squashes the load on the port this cycle by not loading stage 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v    <= '0;
      tag_lane <= '0;
    end else if (flush_i) begin
      tag_v <= '0;
    end else begin
      tag_v[0]    <= dmem_re_o;
      tag_lane[0] <= issue_lane;
      for (int i = 1; i < ReadLatency; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_lane[i] <= tag_lane[i-1];
      end
    end
  end

  always_comb begin
    resp_valid_o = '0;
    resp_rdata_o = '0;
    if (tag_v[ReadLatency-1]) begin
      resp_valid_o[tag_lane[ReadLatency-1]] = 1'b1;
      resp_rdata_o[tag_lane[ReadLatency-1]] = dmem_rdata_i;
    end
  end

  assign busy_o = (dmem_we_o != 4'h0) || dmem_re_o || (tag_v != '0);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  localparam int RL = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0][3:0]   req_we;
  logic [1:0]        req_re;
  logic [1:0]        resp_valid;
  logic [1:0][31:0]  resp_rdata;
  logic              flush;
  logic [31:0]       dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_we;
  logic              dmem_re;
  logic [31:0]       dmem_rdata;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  logic        mem_init;
  logic [31:0] mem     [0:255];
  logic [31:0] rd_pipe [0:RL-1];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.XLEN(32), .ReadLatency(RL)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_we_i     (req_we),
    .req_re_i     (req_re),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .flush_i      (flush),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_we_o    (dmem_we),
    .dmem_re_o    (dmem_re),
    .dmem_rdata_i (dmem_rdata),
    .busy_o       (busy)
  );

  // data_memory model: word i holds i after init, byte-enable writes, RL-cycle reads
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= i;
    end else begin
      for (int b = 0; b < 4; b++)
        if (dmem_we[b]) mem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= mem[dmem_addr[9:2]];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign dmem_rdata = rd_pipe[RL-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_valid = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = '0;
    req_re    = 2'b00;
    flush     = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    mem_init = 1'b1;
    idle();
    cyc(); settle();
    check("rst_ready", req_ready, 2'b00);
    check("rst_we", dmem_we, 4'h0);
    check("rst_re", dmem_re, 1'b0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp", resp_valid, 2'b00);
    cyc();
    cyc(); reset = 1'b0; mem_init = 1'b0;

    // T2 same-cycle store (lane 0) and load (lane 1) to 0x40
    cyc();
    req_valid = 2'b11;
    req_we[0] = 4'hF; req_wdata[0] = 32'hDEADBEEF; req_addr[0] = 32'h40;
    req_re[1] = 1'b1; req_addr[1] = 32'h40;
    settle();
    check("t2_ready_both", req_ready, 2'b01);
    cyc();
    req_valid = 2'b10; req_we[0] = 4'h0;
    settle();
    check("t2_ready_l1", req_ready, 2'b11);
    check("t2_st_we", dmem_we, 4'hF);
    check("t2_st_addr", dmem_addr, 32'h40);
    check("t2_st_wdata", dmem_wdata, 32'hDEADBEEF);
    check("t2_st_re", dmem_re, 1'b0);
    cyc(); idle(); settle();
    check("t2_ld_re", dmem_re, 1'b1);
    check("t2_ld_we", dmem_we, 4'h0);
    check("t2_busy", busy, 1'b1);
    cyc(); settle();
    check("t2_no_early_resp", resp_valid, 2'b00);
    cyc(); settle();
    check("t2_resp_valid", resp_valid, 2'b10);
    check("t2_resp_data1", resp_rdata[1], 32'hDEADBEEF);
    check("t2_resp_data0", resp_rdata[0], 32'h0);
    cyc(); settle();
    check("t2_resp_done", resp_valid, 2'b00);
    check("t2_idle_busy", busy, 1'b0);

    // T3 back-to-back loads, lane 0 x3 then lane 1
    cyc(); req_valid = 2'b01; req_re[0] = 1'b1; req_addr[0] = 32'h0;
    cyc(); req_addr[0] = 32'h4;
    cyc(); req_addr[0] = 32'h8;
    cyc(); idle(); req_valid = 2'b10; req_re[1] = 1'b1; req_addr[1] = 32'hC;
    settle();
    check("t3_ready_l1", req_ready, 2'b11);
    check("t3_resp0_v", resp_valid, 2'b01);
    check("t3_resp0_d", resp_rdata[0], 32'd0);
    cyc(); idle(); settle();
    check("t3_resp1_v", resp_valid, 2'b01);
    check("t3_resp1_d", resp_rdata[0], 32'd1);
    cyc(); settle();
    check("t3_resp2_v", resp_valid, 2'b01);
    check("t3_resp2_d", resp_rdata[0], 32'd2);
    cyc(); settle();
    check("t3_resp3_v", resp_valid, 2'b10);
    check("t3_resp3_d", resp_rdata[1], 32'd3);
    cyc(); settle();
    check("t3_resp_end", resp_valid, 2'b00);

    // T4 flush drops an issued load and blocks a new store
    cyc(); req_valid = 2'b10; req_re[1] = 1'b1; req_addr[1] = 32'h20;
    cyc(); idle(); flush = 1'b1;
    req_valid = 2'b01; req_we[0] = 4'hF; req_addr[0] = 32'h24; req_wdata[0] = 32'h12345678;
    settle();
    check("t4_re", dmem_re, 1'b1);
    check("t4_addr", dmem_addr, 32'h20);
    check("t4_ready_flush", req_ready, 2'b00);
    cyc(); idle(); settle();
    check("t4_busy", busy, 1'b0);
    check("t4_no_store", dmem_we, 4'h0);
    cyc(); settle();
    check("t4_no_resp_a", resp_valid, 2'b00);
    cyc(); settle();
    check("t4_no_resp_b", resp_valid, 2'b00);

    // T5 partial store with re also set
    cyc(); req_valid = 2'b10; req_we[1] = 4'b0110; req_re[1] = 1'b1;
    req_wdata[1] = 32'h00ABCD00; req_addr[1] = 32'h80;
    cyc(); idle(); settle();
    check("t5_we", dmem_we, 4'b0110);
    check("t5_re", dmem_re, 1'b0);
    check("t5_wdata", dmem_wdata, 32'h00ABCD00);
    cyc(); settle();
    check("t5_we_once", dmem_we, 4'h0);
    check("t5_busy", busy, 1'b0);
    check("t5_mem", mem[32], 32'h00ABCD20);
    cyc(); settle();
    check("t5_no_resp", resp_valid, 2'b00);

    // T6 no-op request
    cyc(); req_valid = 2'b01; req_addr[0] = 32'h55; settle();
    check("t6_ready", req_ready[0], 1'b1);
    cyc(); idle(); settle();
    check("t6_we", dmem_we, 4'h0);
    check("t6_re", dmem_re, 1'b0);
    check("t6_busy", busy, 1'b0);
    cyc(); settle();
    check("t6_busy2", busy, 1'b0);
    check("t6_no_resp", resp_valid, 2'b00);

    // T1 reset while a load is in flight
    cyc(); req_valid = 2'b01; req_re[0] = 1'b1; req_addr[0] = 32'h100;
    cyc(); idle(); settle();
    check("t1_re", dmem_re, 1'b1);
    cyc(); reset = 1'b1; settle();
    check("t1_busy", busy, 1'b0);
    check("t1_addr", dmem_addr, 32'h0);
    check("t1_resp", resp_valid, 2'b00);
    check("t1_ready", req_ready, 2'b00);
    cyc(); reset = 1'b0; settle();
    check("t1_after_a", resp_valid, 2'b00);
    cyc(); settle();
    check("t1_after_b", resp_valid, 2'b00);
    cyc(); settle();
    check("t1_after_c", resp_valid, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
